// File: rtl/chunk_fifo.sv
// Show-ahead word FIFO between the chunker and the output port; sticky overflow on loss.
// Optional CHUNK_FIFO_DROPCNT_EN adds a saturating 16-bit drop_count output.
module chunk_fifo #(
  parameter int M     = 32,
  parameter int DEPTH = 16,
  parameter int AFULL = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [M-1:0]             din,
  input  logic                     din_valid,
  output logic [M-1:0]             dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overflow
`ifdef CHUNK_FIFO_DROPCNT_EN
  ,
  output logic [15:0]              drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CDEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] CAFULL = (AW+1)'(AFULL);

  logic [M-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;
  logic          push;
  logic          drop;

  assign empty       = (count == '0);
  assign full        = (count == CDEPTH);
  assign almost_full = (count >= CAFULL);
  assign dout_valid  = !empty;
  assign dout        = empty ? '0 : mem[rd_ptr];

  assign pop  = dout_valid && dout_ready;
  assign push = din_valid && (!full || pop);
  assign drop = din_valid && full && !pop;

  // Storage is never cleared; reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (push && !reset)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      if (drop)
        overflow <= 1'b1;
    end
  end

`ifdef CHUNK_FIFO_DROPCNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_chunk_fifo.sv
// Directed bench for chunk_fifo with a queue scoreboard and per-cycle model checks.
// Checks drop_count too when CHUNK_FIFO_DROPCNT_EN is defined.
module tb_chunk_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] din;
  logic        din_valid;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        almost_full;
  logic        overflow;
`ifdef CHUNK_FIFO_DROPCNT_EN
  logic [15:0] drop_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] sb[$];
  int          m_count = 0;
  logic        m_ovf   = 1'b0;
  int          m_drop  = 0;

  always #5 clk = ~clk;

  chunk_fifo #(.M(32), .DEPTH(16), .AFULL(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .almost_full(almost_full),
    .overflow   (overflow)
`ifdef CHUNK_FIFO_DROPCNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic dv,
                       input logic [31:0] d, input logic rdy);
    logic pop;
    logic push;
    logic [31:0] exp;
    @(negedge clk);
    reset      = rst;
    din_valid  = dv;
    din        = d;
    dout_ready = rdy;
    #1;
    chk("count", 32'(count), 32'(m_count));
    chk("empty", 32'(empty), 32'(m_count == 0));
    chk("full", 32'(full), 32'(m_count == 16));
    chk("almost_full", 32'(almost_full), 32'(m_count >= 12));
    chk("dout_valid", 32'(dout_valid), 32'(m_count != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef CHUNK_FIFO_DROPCNT_EN
    chk("drop_count", 32'(drop_count), 32'(m_drop));
`endif
    exp = (m_count != 0) ? sb[0] : 32'h0;
    chk("dout", dout, exp);
    @(posedge clk);
    if (rst) begin
      sb.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      m_drop  = 0;
    end else begin
      pop  = (m_count != 0) && rdy;
      push = dv && (m_count < 16 || pop);
      if (pop)
        void'(sb.pop_front());
      if (push)
        sb.push_back(d);
      if (dv && !push) begin
        m_ovf = 1'b1;
        if (m_drop < 16'hFFFF)
          m_drop++;
      end
      m_count = m_count + int'(push) - int'(pop);
    end
  endtask

  initial begin
    reset      = 1'b1;
    din_valid  = 1'b0;
    din        = '0;
    dout_ready = 1'b0;

    // reset for two cycles, then idle check
    cycle(1, 1, 32'hDEAD0000, 1);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    chk("rst_dout", dout, 32'h0);

    // 4-word burst, then drain
    for (int i = 0; i < 4; i++)
      cycle(0, 1, 32'hA0000000 + 32'(i), 0);
    cycle(0, 0, 0, 0);
    chk("burst_count", 32'(count), 32'd4);
    chk("burst_head", dout, 32'hA0000000);
    for (int i = 0; i < 5; i++)
      cycle(0, 0, 0, 1);

    // fill past full, then drain
    for (int i = 1; i <= 17; i++)
      cycle(0, 1, 32'(i), 0);
    cycle(0, 0, 0, 0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 17; i++)
      cycle(0, 0, 0, 1);
    chk("drain_ovf", 32'(overflow), 32'd1);

    // simultaneous push/pop at full across wrap
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      cycle(0, 1, 32'hB0000000 + 32'(i), 0);
    for (int i = 16; i < 36; i++)
      cycle(0, 1, 32'hB0000000 + 32'(i), 1);
    cycle(0, 0, 0, 0);
    chk("pp_count", 32'(count), 32'd16);
    chk("pp_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 17; i++)
      cycle(0, 0, 0, 1);

    // random backpressure with periodic bursts
    for (int i = 0; i < 36; i++)
      cycle(0, (i % 6) < 4, 32'hC0000000 + 32'(i), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 20; i++)
      cycle(0, 0, 0, 1);
    chk("bp_no_drop", 32'(overflow), 32'd0);

    // reset in the middle of a burst
    for (int i = 0; i < 3; i++)
      cycle(0, 1, 32'hD0000000 + 32'(i), 0);
    cycle(1, 1, 32'hD0000003, 0);
    cycle(0, 0, 0, 0);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_valid", 32'(dout_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
